// File: rtl/scr1_ahb_ram_arb_pkg.sv
// Shared types and helpers for the imem/dmem AHB-Lite RAM arbiter.
package scr1_ahb_ram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD,
    ST_ERR1,
    ST_ERR2
  } port_st_e;

  localparam int unsigned HTRANS_ACT = 1;

  localparam logic [2:0] HSIZE_B = 3'd0;
  localparam logic [2:0] HSIZE_H = 3'd1;
  localparam logic [2:0] HSIZE_W = 3'd2;

  function automatic logic [3:0] size2be(
    input logic [2:0] hsize,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (1'b1)
      (hsize == HSIZE_B): be = 4'b0001 << a;
      (hsize == HSIZE_H): be = a[1] ? 4'b1100 : 4'b0011;
      default:            be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic addr_ok(
    input logic [31:0] haddr,
    input logic [31:0] base,
    input int unsigned aw,
    input logic [2:0]  hsize
  );
    logic win;
    logic al;
    win = ((haddr ^ base) >> (aw + 2)) == 32'd0;
    al  = 1'b0;
    unique case (1'b1)
      (hsize == HSIZE_B): al = 1'b1;
      (hsize == HSIZE_H): al = ~haddr[0];
      (hsize == HSIZE_W): al = (haddr[1:0] == 2'b00);
      default:            al = 1'b0;
    endcase
    return win & al;
  endfunction

endpackage

// File: rtl/scr1_ahb_ram_port.sv
// One AHB-Lite slave port: address capture, wait/read/error sequencing.
module scr1_ahb_ram_port
  import scr1_ahb_ram_arb_pkg::*;
#(
  parameter int          RAM_AW = 14,
  parameter logic [31:0] BASE   = 32'hFFEF_0000,
  parameter bit          WR_EN  = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_hsel,
  input  logic [1:0]        i_htrans,
  input  logic [2:0]        i_hsize,
  input  logic              i_hwrite,
  input  logic [31:0]       i_haddr,
  input  logic              i_grant,
  input  logic [31:0]       i_ram_rdata,
  output logic              o_hready,
  output logic              o_hresp,
  output logic [31:0]       o_hrdata,
  output logic              o_req,
  output logic              o_we,
  output logic [RAM_AW-1:0] o_addr,
  output logic [3:0]        o_be
);

  port_st_e          r_st;
  logic [RAM_AW-1:0] r_addr;
  logic [1:0]        r_lsb;
  logic [2:0]        r_size;
  logic              r_we;

  logic w_acc;
  logic w_ok;

  always_comb begin
    o_hready = 1'b1;
    o_hresp  = 1'b0;
    unique case (r_st)
      ST_WAIT: o_hready = i_grant & r_we;
      ST_ERR1: begin
        o_hready = 1'b0;
        o_hresp  = 1'b1;
      end
      ST_ERR2: o_hresp = 1'b1;
      default: ;
    endcase
  end

  assign w_acc    = i_hsel & i_htrans[HTRANS_ACT] & o_hready;
  assign w_ok     = addr_ok(i_haddr, BASE, RAM_AW, i_hsize);
  assign o_hrdata = (r_st == ST_RD) ? i_ram_rdata : '0;
  assign o_req    = (r_st == ST_WAIT);
  assign o_we     = r_we;
  assign o_addr   = r_addr;
  assign o_be     = r_we ? size2be(r_size, r_lsb) : 4'b1111;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st   <= ST_IDLE;
      r_addr <= '0;
      r_lsb  <= '0;
      r_size <= '0;
      r_we   <= 1'b0;
    end else if (w_acc) begin
      r_st   <= w_ok ? ST_WAIT : ST_ERR1;
      r_addr <= i_haddr[RAM_AW+1:2];
      r_lsb  <= i_haddr[1:0];
      r_size <= i_hsize;
      r_we   <= WR_EN & i_hwrite;
    end else begin
      unique case (r_st)
        ST_WAIT: if (i_grant) r_st <= r_we ? ST_IDLE : ST_RD;
        ST_ERR1: r_st <= ST_ERR2;
        default: r_st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/scr1_ahb_ram_arb.sv
// Shares one single-port RAM between the imem and dmem AHB-Lite ports.
module scr1_ahb_ram_arb
  import scr1_ahb_ram_arb_pkg::*;
#(
  parameter int          RAM_AW     = 14,
  parameter logic [31:0] IMEM_BASE  = 32'hFFEF_0000,
  parameter logic [31:0] DMEM_BASE  = 32'hFFEF_0000,
  parameter int          STARVE_LIM = 4
) (
  input  logic              cpu_clk,
  input  logic              pwrup_rst_n,
  input  logic              imem_hsel,
  input  logic [1:0]        imem_htrans,
  input  logic [2:0]        imem_hsize,
  input  logic [31:0]       imem_haddr,
  output logic              imem_hready,
  output logic              imem_hresp,
  output logic [31:0]       imem_hrdata,
  input  logic              dmem_hsel,
  input  logic [1:0]        dmem_htrans,
  input  logic [2:0]        dmem_hsize,
  input  logic              dmem_hwrite,
  input  logic [31:0]       dmem_haddr,
  input  logic [31:0]       dmem_hwdata,
  output logic              dmem_hready,
  output logic              dmem_hresp,
  output logic [31:0]       dmem_hrdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

  logic              w_i_req, w_d_req;
  logic              w_i_gnt, w_d_gnt;
  logic              w_i_we, w_d_we;
  logic [RAM_AW-1:0] w_i_addr, w_d_addr;
  logic [3:0]        w_i_be, w_d_be;
  logic [SW-1:0]     r_starve;

  scr1_ahb_ram_port #(
    .RAM_AW (RAM_AW),
    .BASE   (IMEM_BASE),
    .WR_EN  (1'b0)
  ) u_imem (
    .i_clk       (cpu_clk),
    .i_rst_n     (pwrup_rst_n),
    .i_hsel      (imem_hsel),
    .i_htrans    (imem_htrans),
    .i_hsize     (imem_hsize),
    .i_hwrite    (1'b0),
    .i_haddr     (imem_haddr),
    .i_grant     (w_i_gnt),
    .i_ram_rdata (ram_rdata),
    .o_hready    (imem_hready),
    .o_hresp     (imem_hresp),
    .o_hrdata    (imem_hrdata),
    .o_req       (w_i_req),
    .o_we        (w_i_we),
    .o_addr      (w_i_addr),
    .o_be        (w_i_be)
  );

  scr1_ahb_ram_port #(
    .RAM_AW (RAM_AW),
    .BASE   (DMEM_BASE),
    .WR_EN  (1'b1)
  ) u_dmem (
    .i_clk       (cpu_clk),
    .i_rst_n     (pwrup_rst_n),
    .i_hsel      (dmem_hsel),
    .i_htrans    (dmem_htrans),
    .i_hsize     (dmem_hsize),
    .i_hwrite    (dmem_hwrite),
    .i_haddr     (dmem_haddr),
    .i_grant     (w_d_gnt),
    .i_ram_rdata (ram_rdata),
    .o_hready    (dmem_hready),
    .o_hresp     (dmem_hresp),
    .o_hrdata    (dmem_hrdata),
    .o_req       (w_d_req),
    .o_we        (w_d_we),
    .o_addr      (w_d_addr),
    .o_be        (w_d_be)
  );

  // dmem has priority until imem has lost STARVE_LIM times in a row
  assign w_i_gnt = w_i_req & (~w_d_req | (r_starve == LIM));
  assign w_d_gnt = w_d_req & ~w_i_gnt;

  always_ff @(posedge cpu_clk or negedge pwrup_rst_n) begin
    if (!pwrup_rst_n) begin
      r_starve <= '0;
    end else if (w_i_req & w_d_gnt) begin
      if (r_starve != LIM) r_starve <= r_starve + 1'b1;
    end else begin
      r_starve <= '0;
    end
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      w_d_gnt: begin
        ram_en    = 1'b1;
        ram_we    = w_d_we;
        ram_be    = w_d_be;
        ram_addr  = w_d_addr;
        ram_wdata = w_d_we ? dmem_hwdata : '0;
      end
      w_i_gnt: begin
        ram_en   = 1'b1;
        ram_we   = w_i_we;
        ram_be   = w_i_be;
        ram_addr = w_i_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_scr1_ahb_ram_arb.sv
// Scoreboard bench for scr1_ahb_ram_arb: queued AHB drivers, RAM model, monitors.
module tb_scr1_ahb_ram_arb;

  typedef struct {
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
  } cmd_t;

  typedef struct {
    logic        resp;
    logic [31:0] d;
    int          waits;
  } exp_t;

  typedef struct {
    logic [13:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } wexp_t;

  logic        cpu_clk = 1'b0;
  logic        pwrup_rst_n = 1'b0;
  logic        imem_hsel = 1'b0;
  logic [1:0]  imem_htrans = 2'b00;
  logic [2:0]  imem_hsize = 3'd2;
  logic [31:0] imem_haddr = '0;
  logic        imem_hready, imem_hresp;
  logic [31:0] imem_hrdata;
  logic        dmem_hsel = 1'b0;
  logic [1:0]  dmem_htrans = 2'b00;
  logic [2:0]  dmem_hsize = 3'd2;
  logic        dmem_hwrite = 1'b0;
  logic [31:0] dmem_haddr = '0;
  logic [31:0] dmem_hwdata = '0;
  logic        dmem_hready, dmem_hresp;
  logic [31:0] dmem_hrdata;
  logic        ram_en, ram_we;
  logic [3:0]  ram_be;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  scr1_ahb_ram_arb dut (
    .cpu_clk     (cpu_clk),
    .pwrup_rst_n (pwrup_rst_n),
    .imem_hsel   (imem_hsel),
    .imem_htrans (imem_htrans),
    .imem_hsize  (imem_hsize),
    .imem_haddr  (imem_haddr),
    .imem_hready (imem_hready),
    .imem_hresp  (imem_hresp),
    .imem_hrdata (imem_hrdata),
    .dmem_hsel   (dmem_hsel),
    .dmem_htrans (dmem_htrans),
    .dmem_hsize  (dmem_hsize),
    .dmem_hwrite (dmem_hwrite),
    .dmem_haddr  (dmem_haddr),
    .dmem_hwdata (dmem_hwdata),
    .dmem_hready (dmem_hready),
    .dmem_hresp  (dmem_hresp),
    .dmem_hrdata (dmem_hrdata),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_be      (ram_be),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_ramen = 0;
  int n_wr = 0;

  cmd_t  iq[$], dq[$];
  exp_t  isb[$], dsb[$];
  wexp_t wsb[$];

  bit   drv_on = 1'b1;
  bit   have_i = 1'b0, have_d = 1'b0;
  bit   i_acc = 1'b0, d_acc = 1'b0;
  bit   i_pend = 1'b0, d_pend = 1'b0;
  int   i_wt = 0, d_wt = 0;
  cmd_t icur, dcur;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // RAM model: synchronous single port, read data one cycle after ram_en
  logic [31:0] mem [0:16383];
  always @(posedge cpu_clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  // Drivers: present queued commands, hold hwdata through the data phase
  initial forever begin
    @(posedge cpu_clk);
    #1;
    if (drv_on) begin
      if (d_acc) begin
        dmem_hwdata = dcur.wd;
        have_d = 1'b0;
      end
      if (!have_d && dq.size() != 0) begin
        dcur = dq.pop_front();
        have_d = 1'b1;
      end
      dmem_hsel   = have_d;
      dmem_htrans = have_d ? 2'b10 : 2'b00;
      dmem_hwrite = dcur.wr;
      dmem_hsize  = dcur.sz;
      dmem_haddr  = dcur.a;
    end
  end

  initial forever begin
    @(posedge cpu_clk);
    #1;
    if (drv_on) begin
      if (i_acc) have_i = 1'b0;
      if (!have_i && iq.size() != 0) begin
        icur = iq.pop_front();
        have_i = 1'b1;
      end
      imem_hsel   = have_i;
      imem_htrans = have_i ? 2'b10 : 2'b00;
      imem_hsize  = icur.sz;
      imem_haddr  = icur.a;
    end
  end

  // dmem monitor
  initial forever begin
    @(negedge cpu_clk);
    d_acc = dmem_hsel & dmem_htrans[1] & dmem_hready;
    if (!pwrup_rst_n) begin
      d_pend = 1'b0;
    end else begin
      if (d_pend) begin
        if (dmem_hready) begin
          if (dsb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL d_unexpected: response with empty scoreboard");
          end else begin
            exp_t e;
            e = dsb.pop_front();
            chk("d_hresp", 32'(dmem_hresp), 32'(e.resp));
            chk("d_hrdata", dmem_hrdata, e.d);
            chk("d_waits", d_wt, e.waits);
          end
          d_pend = 1'b0;
        end else begin
          d_wt++;
          if (dsb.size() != 0)
            chk("d_hresp_wait", 32'(dmem_hresp), 32'(dsb[0].resp));
          chk("d_hrdata_wait", dmem_hrdata, 32'h0);
        end
      end
      if (d_acc) begin
        d_pend = 1'b1;
        d_wt = 0;
      end
    end
  end

  // imem monitor
  initial forever begin
    @(negedge cpu_clk);
    i_acc = imem_hsel & imem_htrans[1] & imem_hready;
    if (!pwrup_rst_n) begin
      i_pend = 1'b0;
    end else begin
      if (i_pend) begin
        if (imem_hready) begin
          if (isb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL i_unexpected: response with empty scoreboard");
          end else begin
            exp_t e;
            e = isb.pop_front();
            chk("i_hresp", 32'(imem_hresp), 32'(e.resp));
            chk("i_hrdata", imem_hrdata, e.d);
            chk("i_waits", i_wt, e.waits);
          end
          i_pend = 1'b0;
        end else begin
          i_wt++;
          if (isb.size() != 0)
            chk("i_hresp_wait", 32'(imem_hresp), 32'(isb[0].resp));
          chk("i_hrdata_wait", imem_hrdata, 32'h0);
        end
      end
      if (i_acc) begin
        i_pend = 1'b1;
        i_wt = 0;
      end
    end
  end

  // RAM write monitor
  initial forever begin
    @(negedge cpu_clk);
    if (ram_en) n_ramen++;
    if (ram_we) begin
      n_wr++;
      if (wsb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL ram_wr_unexpected: addr %h be %b data %h",
                 ram_addr, ram_be, ram_wdata);
      end else begin
        wexp_t w;
        w = wsb.pop_front();
        chk("ram_addr", 32'(ram_addr), 32'(w.a));
        chk("ram_be", 32'(ram_be), 32'(w.be));
        chk("ram_wdata", ram_wdata, w.d);
      end
    end
  end

  task automatic d_op(input bit wr, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input bit resp, input logic [31:0] rd, input int wt);
    dq.push_back(cmd_t'{wr, sz, a, wd});
    dsb.push_back(exp_t'{resp, rd, wt});
  endtask

  task automatic i_op(input logic [2:0] sz, input logic [31:0] a,
                      input bit resp, input logic [31:0] rd, input int wt);
    iq.push_back(cmd_t'{1'b0, sz, a, 32'h0});
    isb.push_back(exp_t'{resp, rd, wt});
  endtask

  task automatic exp_wr(input logic [13:0] a, input logic [3:0] be,
                        input logic [31:0] d);
    wsb.push_back(wexp_t'{a, be, d});
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((dq.size() != 0 || iq.size() != 0 || have_d || have_i ||
            d_pend || i_pend || dsb.size() != 0 || isb.size() != 0 ||
            wsb.size() != 0) && k < 100) begin
      @(negedge cpu_clk);
      k++;
    end
    if (k >= 100) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: waited %0d cycles, limit 100", k);
    end
    repeat (2) @(negedge cpu_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000");
    $fatal(1);
  end

  initial begin
    int ramen0, wr0;
    #3;
    chk("rst_i_hready", 32'(imem_hready), 32'h1);
    chk("rst_i_hresp", 32'(imem_hresp), 32'h0);
    chk("rst_i_hrdata", imem_hrdata, 32'h0);
    chk("rst_d_hready", 32'(dmem_hready), 32'h1);
    chk("rst_d_hresp", 32'(dmem_hresp), 32'h0);
    chk("rst_d_hrdata", dmem_hrdata, 32'h0);
    chk("rst_ram_en", 32'(ram_en), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_be", 32'(ram_be), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    repeat (2) @(negedge cpu_clk);
    pwrup_rst_n = 1'b1;
    @(negedge cpu_clk);

    // word write then readback
    d_op(1, 3'd2, 32'hFFEF_0010, 32'hDEAD_BEEF, 0, 32'h0, 0);
    exp_wr(14'd4, 4'b1111, 32'hDEAD_BEEF);
    d_op(0, 3'd2, 32'hFFEF_0010, 32'h0, 0, 32'hDEAD_BEEF, 1);
    drain();

    // byte and halfword merges
    d_op(1, 3'd2, 32'hFFEF_0010, 32'h1122_3344, 0, 32'h0, 0);
    exp_wr(14'd4, 4'b1111, 32'h1122_3344);
    d_op(1, 3'd0, 32'hFFEF_0013, 32'hAA00_0000, 0, 32'h0, 0);
    exp_wr(14'd4, 4'b1000, 32'hAA00_0000);
    d_op(0, 3'd2, 32'hFFEF_0010, 32'h0, 0, 32'hAA22_3344, 1);
    d_op(1, 3'd2, 32'hFFEF_0014, 32'h0102_0304, 0, 32'h0, 0);
    exp_wr(14'd5, 4'b1111, 32'h0102_0304);
    d_op(1, 3'd1, 32'hFFEF_0016, 32'hBEEF_0000, 0, 32'h0, 0);
    exp_wr(14'd5, 4'b1100, 32'hBEEF_0000);
    d_op(0, 3'd2, 32'hFFEF_0014, 32'h0, 0, 32'hBEEF_0304, 1);
    drain();

    // same-cycle contention: dmem write first, imem sees new data
    i_op(3'd2, 32'hFFEF_0020, 0, 32'h0000_0055, 2);
    d_op(1, 3'd2, 32'hFFEF_0020, 32'h0000_0055, 0, 32'h0, 0);
    exp_wr(14'd8, 4'b1111, 32'h0000_0055);
    drain();

    // back-to-back dmem writes starve imem for exactly four wins
    i_op(3'd2, 32'hFFEF_0030, 0, 32'h0000_00A0, 5);
    for (int k = 0; k < 5; k++) begin
      d_op(1, 3'd2, 32'hFFEF_0030 + 32'(4 * k), 32'h0000_00A0 + 32'(k),
           0, 32'h0, (k == 4) ? 1 : 0);
      exp_wr(14'd12 + 14'(k), 4'b1111, 32'h0000_00A0 + 32'(k));
    end
    drain();

    // back-to-back dmem reads leave gaps that imem takes
    i_op(3'd2, 32'hFFEF_003C, 0, 32'h0000_00A3, 2);
    for (int k = 0; k < 3; k++)
      d_op(0, 3'd2, 32'hFFEF_0030 + 32'(4 * k), 32'h0,
           0, 32'h0000_00A0 + 32'(k), 1);
    drain();

    // error responses never touch the RAM
    ramen0 = n_ramen;
    d_op(0, 3'd2, 32'hFFEF_0002, 32'h0, 1, 32'h0, 1);
    d_op(0, 3'd3, 32'hFFEF_0010, 32'h0, 1, 32'h0, 1);
    d_op(1, 3'd1, 32'hFFEF_0011, 32'h1234_5678, 1, 32'h0, 1);
    i_op(3'd2, 32'h0000_1000, 1, 32'h0, 1);
    i_op(3'd1, 32'hFFEF_0001, 1, 32'h0, 1);
    drain();
    chk("err_ram_en_cycles", 32'(n_ramen - ramen0), 32'h0);

    // reset during a granted dmem write
    drv_on = 1'b0;
    wr0 = n_wr;
    @(negedge cpu_clk);
    dmem_hsel = 1'b1;
    dmem_htrans = 2'b10;
    dmem_hwrite = 1'b1;
    dmem_hsize = 3'd2;
    dmem_haddr = 32'hFFEF_0040;
    @(posedge cpu_clk);
    #1;
    dmem_hsel = 1'b0;
    dmem_htrans = 2'b00;
    dmem_hwdata = 32'h1234_5678;
    #1;
    pwrup_rst_n = 1'b0;
    #1;
    chk("mid_rst_d_hready", 32'(dmem_hready), 32'h1);
    chk("mid_rst_d_hresp", 32'(dmem_hresp), 32'h0);
    chk("mid_rst_ram_en", 32'(ram_en), 32'h0);
    chk("mid_rst_ram_we", 32'(ram_we), 32'h0);
    chk("mid_rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("mid_rst_ram_wdata", ram_wdata, 32'h0);
    repeat (2) @(negedge cpu_clk);
    pwrup_rst_n = 1'b1;
    repeat (4) @(negedge cpu_clk);
    chk("post_rst_writes", 32'(n_wr - wr0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
